id_ex_hazard_controller: RTL and testbench
==========================================

# id_ex_hazard_controller

Control block for the segmented core that governs the ID/EX boundary. It detects load-use hazards between the instruction leaving IF/ID and the load sitting in ID/EX. It holds PC and IF/ID and inserts bubbles into ID/EX for a configurable number of cycles. It also flushes IF/ID and ID/EX when EX resolves a taken branch or jump, and keeps saturating stall/flush statistics.

## Interface
- STALL_CYCLES, default 1: cycles ID is held per load-use hazard, legal range 1..3 (1 = full MEM→EX forwarding).
- CNT_W, default 16: width of the statistics counters.

- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_instruction  in  32  IF/ID instruction_out
- ex_instruction  in  32  ID/EX instruction_out
- ex_valid  in  1  ID/EX holds a real instruction, not a bubble
- branch_taken_ex  in  1  EX redirects the PC (taken branch, JAL, JALR)
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP 0x00000013
- id_ex_bubble  out  1  ID/EX loads NOP, and ex_valid is cleared
- stalling  out  1  FSM is in LOAD_STALL
- stall_cycles  out  CNT_W  saturating count of stalled cycles
- flush_events  out  CNT_W  saturating count of branch flushes

## Operation
- ex_is_load: ex_valid, ex opcode 7'b0000011, and ex rd ([11:7]) != 0.
- rs1 is used by every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
- rs2 is used only by R 0110011, S 0100011 and B 1100011.
- hazard: ex_is_load, and the ex rd equals a used id rs1 ([19:15]) or a used id rs2 ([24:20]).
- FSM states:
  - RUN
  - LOAD_STALL, with a remaining-cycle counter rem (2 bits).
- RUN with hazard and no branch_taken_ex:
  - stall this cycle (Mealy).
  - If STALL_CYCLES > 1, go to LOAD_STALL with rem = STALL_CYCLES-1.
  - Otherwise stay in RUN.
- LOAD_STALL: stall every cycle; rem decrements. Return to RUN on the cycle rem == 1.
- Stall outputs: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1.
- branch_taken_ex has priority over any stall:
  - outputs pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - next state RUN, rem=0.
  - flush_events increments.
- Idle outputs (no hazard, no branch): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- stall_cycles increments on every cycle with pc_write=0.
- Both statistics counters saturate at all-ones and never wrap.

## Timing
- Reset values:
  - state RUN, rem 0, both counters 0, stalling 0.
  - Combinational outputs show idle values, unless a branch or hazard is presented while in reset.
  - stall_cycles and flush_events do not increment while rst_n=0.
- Hazard latency: the stall is visible in the same cycle the hazard is presented.
- Total stall length per hazard: exactly STALL_CYCLES consecutive cycles.
- stalling is registered. It is 1 during cycles 2..STALL_CYCLES of a stall and 0 during the first.
- A hazard presented in the cycle LOAD_STALL exits does not retrigger. EX holds a bubble then (ex_valid=0).
- Branch during LOAD_STALL: flush wins and the state returns to RUN on the next edge.
- Branch and hazard in the same RUN cycle: the flush wins, no stall, and stall_cycles does not increment.
- Reset asserted mid-stall: immediate return to RUN, counters cleared, outputs idle.

## Structure
- Shared riscv_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_R, OP_LUI, OP_AUIPC, OP_JAL)
  - NOP_INSTR = 32'h00000013
  - hazard_state_t enum {RUN, LOAD_STALL}
- Sub-module: hazard_reg_use_decode. It is combinational and takes an instruction to uses_rs1/uses_rs2. Other units reuse it.
- The FSM, the counters and the output mux live in the top module.
- The wiring designator connects this block's outputs to the PC, IF/ID and ID/EX enables.

## Test plan
- Hazard on rs1, STALL_CYCLES=1:
  - Stimulus: ex=0x0000A283 (lw x5,0(x1)) with ex_valid=1, id=0x00228333 (add x6,x5,x2).
  - Required: one cycle with pc_write=0 and id_ex_bubble=1, stall_cycles=1.
- Same pair with STALL_CYCLES=3:
  - Required: 3 stall cycles; stalling=0,1,1 over those cycles; back to RUN with idle outputs.
- No false hazards:
  - Required: no stall for ex=0x0000A003 (lw x0), for ex_valid=0, or for id=0x000283B7 (lui x7 with bits 19:15=5).
- Hazard on rs2:
  - Stimulus: id=0x00512023 (sw x5,0(x2)) behind lw x5.
  - Required: stall; the same instruction with the ex opcode changed to R-type gives no stall.
- Branch priority:
  - Stimulus: branch_taken_ex=1 together with the hazard, then branch_taken_ex=1 during LOAD_STALL.
  - Required: if_id_flush=1, pc_write=1, state RUN next cycle, flush_events incremented.
  - Required: stall_cycles unchanged in the shared cycle.
- Reset and saturation:
  - Stimulus: drop rst_n mid LOAD_STALL.
  - Required: state RUN and counters 0 immediately.
  - Stimulus: with CNT_W=4, run 20 stall cycles.
  - Required: stall_cycles holds at 15.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V opcode constants, field helpers and hazard FSM states
//
// Purpose: common definitions for pipeline control blocks.
// Contents: opcode constants, NOP encoding, hazard_state_t, and field helpers
//           that pull opcode / rd / rs1 / rs2 out of a 32-bit instruction.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } hazard_state_t;

    function automatic logic [6:0] instr_opcode(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [4:0] instr_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] instr_rs1(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] instr_rs2(input logic [31:0] instr);
        return instr[24:20];
    endfunction

endpackage

// File: rtl/hazard_reg_use_decode.sv
// rtl/hazard_reg_use_decode.sv - combinational source-register usage decode
//
// Purpose: tells whether an instruction actually reads rs1 and/or rs2, so that
//          hazard checks ignore register fields that are really immediates.
// Ports:
//   instruction  in  32  instruction word to classify
//   uses_rs1     out 1   instruction reads rs1 ([19:15])
//   uses_rs2     out 1   instruction reads rs2 ([24:20])
module hazard_reg_use_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instruction,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;

    // Only the opcode decides register usage; the remaining fields are folded
    // into a sink so the port stays a full instruction word.
    logic unused_fields;

    assign opcode        = instr_opcode(instruction);
    assign unused_fields = ^instruction[31:7];

    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
            default:                  uses_rs1 = 1'b1;
        endcase
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
            default:                   uses_rs2 = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_ex_hazard_controller.sv
// rtl/id_ex_hazard_controller.sv - load-use stall and branch flush control at the ID/EX boundary
//
// Purpose: detects load-use hazards between IF/ID and a load in ID/EX, holds PC
//          and IF/ID while bubbling ID/EX for STALL_CYCLES cycles, flushes on a
//          taken branch/jump resolved in EX, and keeps saturating statistics.
// Parameters:
//   STALL_CYCLES  cycles ID is held per load-use hazard (1..3)
//   CNT_W         width of the statistics counters
// Ports:
//   clk              in  1      core clock
//   rst_n            in  1      asynchronous active-low reset
//   id_instruction   in  32     IF/ID instruction
//   ex_instruction   in  32     ID/EX instruction
//   ex_valid         in  1      ID/EX holds a real instruction
//   branch_taken_ex  in  1      EX redirects the PC
//   pc_write         out 1      PC update enable
//   if_id_write      out 1      IF/ID load enable
//   if_id_flush      out 1      IF/ID loads NOP
//   id_ex_bubble     out 1      ID/EX loads NOP, ex_valid cleared
//   stalling         out 1      FSM is in LOAD_STALL
//   stall_cycles     out CNT_W  saturating count of cycles with pc_write=0
//   flush_events     out CNT_W  saturating count of branch flushes
module id_ex_hazard_controller
    import riscv_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instruction,
    input  logic [31:0]      ex_instruction,
    input  logic             ex_valid,
    input  logic             branch_taken_ex,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             stalling,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Cycles still owed after the first (Mealy) stall cycle.
    localparam logic [1:0] REM_INIT = 2'(STALL_CYCLES - 1);

    hazard_state_t state, state_next;
    logic [1:0]    rem, rem_next;

    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       rs1_match;
    logic       rs2_match;
    logic       hazard;

    // Only opcode and rd of the EX instruction matter here.
    logic unused_ex_fields;
    assign unused_ex_fields = ^ex_instruction[31:12];

    hazard_reg_use_decode u_id_decode (
        .instruction (id_instruction),
        .uses_rs1    (id_uses_rs1),
        .uses_rs2    (id_uses_rs2)
    );

    assign ex_rd      = instr_rd(ex_instruction);
    assign ex_is_load = ex_valid
                        && (instr_opcode(ex_instruction) == OP_LOAD)
                        && (ex_rd != 5'd0);
    assign rs1_match  = id_uses_rs1 && (instr_rs1(id_instruction) == ex_rd);
    assign rs2_match  = id_uses_rs2 && (instr_rs2(id_instruction) == ex_rd);
    assign hazard     = ex_is_load && (rs1_match || rs2_match);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= 2'd0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    always_comb begin
        state_next   = state;
        rem_next     = rem;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;

        if (branch_taken_ex) begin
            // A redirect makes both younger instructions dead, so it overrides
            // any pending stall and the FSM restarts clean.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_next   = RUN;
            rem_next     = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_next = LOAD_STALL;
                            rem_next   = REM_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    // Stall unconditionally; the load is already past EX so the
                    // hazard inputs no longer describe it.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (rem == 2'd1) begin
                        state_next = RUN;
                        rem_next   = 2'd0;
                    end else begin
                        rem_next   = rem - 2'd1;
                    end
                end
                default: begin
                    state_next = RUN;
                    rem_next   = 2'd0;
                end
            endcase
        end
    end

    assign stalling = (state == LOAD_STALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (branch_taken_ex && (flush_events != {CNT_W{1'b1}})) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_controller.sv
// tb/tb_id_ex_hazard_controller.sv - scoreboard bench for id_ex_hazard_controller
module tb_id_ex_hazard_controller;

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_BR    = 7'b1100011;
    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_AUIPC = 7'b0010111;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_IMM   = 7'b0010011;
    localparam logic [6:0] T_JALR  = 7'b1100111;
    localparam logic [6:0] T_SYS   = 7'b1110011;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_i = NOP;
    logic [31:0] ex_i = NOP;
    logic        ex_v = 1'b0;
    logic        br = 1'b0;

    always #5 clk = ~clk;

    logic        pw [3];
    logic        iw [3];
    logic        fl [3];
    logic        bb [3];
    logic        st [3];
    logic [15:0] sc0, sc1, fe0, fe1;
    logic [3:0]  sc2, fe2;

    id_ex_hazard_controller #(.STALL_CYCLES(1), .CNT_W(16)) u_sc1 (
        .clk(clk), .rst_n(rst_n), .id_instruction(id_i), .ex_instruction(ex_i),
        .ex_valid(ex_v), .branch_taken_ex(br), .pc_write(pw[0]), .if_id_write(iw[0]),
        .if_id_flush(fl[0]), .id_ex_bubble(bb[0]), .stalling(st[0]),
        .stall_cycles(sc0), .flush_events(fe0));

    id_ex_hazard_controller #(.STALL_CYCLES(3), .CNT_W(16)) u_sc3 (
        .clk(clk), .rst_n(rst_n), .id_instruction(id_i), .ex_instruction(ex_i),
        .ex_valid(ex_v), .branch_taken_ex(br), .pc_write(pw[1]), .if_id_write(iw[1]),
        .if_id_flush(fl[1]), .id_ex_bubble(bb[1]), .stalling(st[1]),
        .stall_cycles(sc1), .flush_events(fe1));

    id_ex_hazard_controller #(.STALL_CYCLES(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_instruction(id_i), .ex_instruction(ex_i),
        .ex_valid(ex_v), .branch_taken_ex(br), .pc_write(pw[2]), .if_id_write(iw[2]),
        .if_id_flush(fl[2]), .id_ex_bubble(bb[2]), .stalling(st[2]),
        .stall_cycles(sc2), .flush_events(fe2));

    typedef struct {
        logic [3:0] ctl;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
        logic       stl;
        int         sc;
        int         fe;
    } exp_t;

    exp_t q [3][$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: stall length and counter ceilings per instance.
    int   m_len [3] = '{1, 3, 2};
    int   m_max [3] = '{65535, 65535, 15};
    int   m_left [3];
    int   m_sc [3];
    int   m_fe [3];
    logic p_pcw [3];
    logic p_valid = 1'b0;
    logic p_br = 1'b0;
    logic p_hz = 1'b0;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic model_hazard(input logic [31:0] id, input logic [31:0] ex,
                                          input logic v);
        logic [6:0] io;
        logic [4:0] rd;
        logic       u1, u2;
        io = id[6:0];
        rd = ex[11:7];
        if (!v || ex[6:0] != T_LOAD || rd == 5'd0) return 1'b0;
        u1 = !(io == T_LUI || io == T_AUIPC || io == T_JAL);
        u2 = (io == T_R || io == T_STORE || io == T_BR);
        return (u1 && id[19:15] == rd) || (u2 && id[24:20] == rd);
    endfunction

    task automatic step(input logic [31:0] id, input logic [31:0] ex,
                        input logic v, input logic b, input logic rn);
        logic hz;
        exp_t e;
        @(posedge clk);
        if (p_valid) begin
            for (int k = 0; k < 3; k++) begin
                if (p_br) begin
                    m_left[k] = 0;
                    if (m_fe[k] < m_max[k]) m_fe[k]++;
                end else if (m_left[k] > 0) begin
                    m_left[k]--;
                end else if (p_hz) begin
                    m_left[k] = m_len[k] - 1;
                end
                if (!p_pcw[k] && m_sc[k] < m_max[k]) m_sc[k]++;
            end
        end
        #1;
        id_i = id; ex_i = ex; ex_v = v; br = b; rst_n = rn;
        hz = model_hazard(id, ex, v);
        for (int k = 0; k < 3; k++) begin
            if (!rn) begin
                m_left[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
            end
            e.stl = (m_left[k] > 0);
            if (b)                        e.ctl = 4'b1111;
            else if (m_left[k] > 0 || hz) e.ctl = 4'b0001;
            else                          e.ctl = 4'b1100;
            e.sc = m_sc[k];
            e.fe = m_fe[k];
            q[k].push_back(e);
            p_pcw[k] = e.ctl[3];
        end
        p_valid = rn; p_br = b; p_hz = hz;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (q[k].size() > 0) begin
                exp_t e;
                logic [3:0] a_ctl;
                int a_sc, a_fe;
                e = q[k].pop_front();
                a_ctl = {pw[k], iw[k], fl[k], bb[k]};
                case (k)
                    0:       begin a_sc = int'(sc0); a_fe = int'(fe0); end
                    1:       begin a_sc = int'(sc1); a_fe = int'(fe1); end
                    default: begin a_sc = int'(sc2); a_fe = int'(fe2); end
                endcase
                checks++;
                if (a_ctl !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl inst%0d t=%0t got %b want %b", k, $time, a_ctl, e.ctl);
                end
                checks++;
                if (st[k] !== e.stl) begin
                    errors++;
                    $display("FAIL stalling inst%0d t=%0t got %b want %b", k, $time, st[k], e.stl);
                end
                checks++;
                if (a_sc != e.sc) begin
                    errors++;
                    $display("FAIL stall_cycles inst%0d t=%0t got %0d want %0d", k, $time, a_sc, e.sc);
                end
                checks++;
                if (a_fe != e.fe) begin
                    errors++;
                    $display("FAIL flush_events inst%0d t=%0t got %0d want %0d", k, $time, a_fe, e.fe);
                end
            end
        end
    end

    localparam logic [31:0] LW5   = 32'h0000A283;  // lw x5,0(x1)
    localparam logic [31:0] LW0   = 32'h0000A003;  // lw x0,0(x1)
    localparam logic [31:0] ADD6  = 32'h00228333;  // add x6,x5,x2
    localparam logic [31:0] LUI7  = 32'h000283B7;  // lui x7 (bits 19:15 = 5)
    localparam logic [31:0] SW5   = 32'h00512023;  // sw x5,0(x2)
    localparam logic [31:0] R5    = 32'h0000A2B3;  // lw x5 with R-type opcode

    logic [6:0] id_ops [10] = '{T_R, T_STORE, T_BR, T_LUI, T_AUIPC, T_JAL, T_IMM, T_LOAD, T_JALR, T_SYS};

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0; m_sc[k] = 0; m_fe[k] = 0; p_pcw[k] = 1'b1;
        end

        // Reset, including a hazard and a branch presented while held in reset.
        step(NOP, NOP, 0, 0, 0);
        step(ADD6, LW5, 1, 0, 0);
        step(ADD6, LW5, 1, 1, 0);
        step(NOP, NOP, 0, 0, 1);

        // rs1 load-use hazard, EX then holds bubbles.
        step(ADD6, LW5, 1, 0, 1);
        repeat (3) step(ADD6, NOP, 0, 0, 1);
        step(NOP, NOP, 0, 0, 1);

        // No false hazards.
        step(ADD6, LW0, 1, 0, 1);
        step(ADD6, LW5, 0, 0, 1);
        step(LUI7, LW5, 1, 0, 1);

        // rs2 hazard, then same pair with EX as R-type.
        step(SW5, LW5, 1, 0, 1);
        repeat (3) step(SW5, NOP, 0, 0, 1);
        step(SW5, R5, 1, 0, 1);

        // Branch with hazard in the same cycle, then branch during LOAD_STALL.
        step(ADD6, LW5, 1, 1, 1);
        step(ADD6, LW5, 1, 0, 1);
        step(ADD6, NOP, 0, 1, 1);
        step(NOP, NOP, 0, 0, 1);

        // Reset dropped in the middle of a stall.
        step(ADD6, LW5, 1, 0, 1);
        step(ADD6, NOP, 0, 0, 0);
        step(ADD6, NOP, 0, 0, 0);
        step(NOP, NOP, 0, 0, 1);

        // Continuous hazard to push the narrow counter into saturation.
        repeat (24) step(ADD6, LW5, 1, 0, 1);
        repeat (20) step(NOP, NOP, 0, 1, 1);
        step(NOP, NOP, 0, 0, 1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] id, ex;
            logic [6:0]  eop;
            int          r;
            id = mk(id_ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            r = $urandom_range(0, 9);
            eop = (r < 7) ? T_LOAD : ((r < 9) ? T_R : T_STORE);
            ex = mk(eop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)));
            step(id, ex, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 199) != 0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q[0].size() + q[1].size() + q[2].size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0",
                     q[0].size() + q[1].size() + q[2].size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
